lighting_ramp_controller: RTL and testbench

Sequential controller placed between the combinational lighting datapath (shade level / active-lamp count computation) and the physical shade motor and lamp drivers. It accepts a new target (shade level, lamp count) through a valid/ready handshake and walks the driven outputs toward that target one step per `STEP_CYCLES` clocks. The shade moves first, then the lamps. This limits inrush current and motor jerk. It reports `busy` while ramping and pulses `done` on completion.

---
 rtl/lighting_pkg.sv | 29 ++
 rtl/lighting_ramp_controller_thermo.sv | 16 +
 rtl/lighting_ramp_controller.sv | 139 +++++++++++++
 tb/tb_lighting_ramp_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lighting_pkg.sv
// Purpose : shared types and constants for the lighting ramp blocks.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: ramp FSM state enum, level/lamp widths, and a helper that moves a
//           level one unit toward its target.
// Config  : none here; LIGHT_PREEMPT_EN is consumed by lighting_ramp_controller.
package lighting_pkg;

  localparam int LIGHT_LEVEL_W   = 4;
  localparam int LIGHT_MAX_LEVEL = 15;
  localparam int LAMP_COUNT      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHADE = 2'd1,
    LAMPS = 2'd2,
    DONE  = 2'd3
  } light_ramp_state_t;

  // One unit toward tgt. Callers only use this when cur != tgt, so the
  // result can never wrap.
  function automatic logic [LIGHT_LEVEL_W-1:0] step_toward(
    input logic [LIGHT_LEVEL_W-1:0] cur,
    input logic [LIGHT_LEVEL_W-1:0] tgt
  );
    return (cur < tgt) ? cur + LIGHT_LEVEL_W'(1) : cur - LIGHT_LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/lighting_ramp_controller_thermo.sv
// Purpose : lamp_thermo_decode, 4-bit lamp count to 16-bit thermometer enables.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : i_count  - active lamp count 0..15
//           o_therm  - bit i set when i < i_count (15 -> 0x7FFF, 0 -> 0x0000)
module lamp_thermo_decode
  import lighting_pkg::*;
(
  input  logic [LIGHT_LEVEL_W-1:0] i_count,
  output logic [LAMP_COUNT-1:0]    o_therm
);

  // (1 << n) - 1 sets exactly the n low bits.
  assign o_therm = (LAMP_COUNT'(1) << i_count) - LAMP_COUNT'(1);

endmodule

// File: rtl/lighting_ramp_controller.sv
// Purpose : walks shade level then lamp count toward a latched target, one
//           unit every STEP_CYCLES clocks, reporting busy and a done pulse.
// Latency : done in cycle ds*S + dl*S + 3 after the accepting edge.
// Backpressure: o_upd_ready high only in IDLE; with LIGHT_PREEMPT_EN defined it
//           is also high in SHADE/LAMPS and a new target restarts the ramp.
// Ports   : i_clk, i_rst (sync, active high); i_upd_valid/o_upd_ready handshake
//           with i_tgt_shade/i_tgt_lamps; o_wshade, o_lightnum, o_lightstate
//           drive the motor and lamps; o_busy, o_done report progress.
// Config  : LIGHT_PREEMPT_EN - accept targets mid-ramp.
module lighting_ramp_controller
  import lighting_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_upd_valid,
  output logic                     o_upd_ready,
  input  logic [LIGHT_LEVEL_W-1:0] i_tgt_shade,
  input  logic [LIGHT_LEVEL_W-1:0] i_tgt_lamps,
  output logic [LIGHT_LEVEL_W-1:0] o_wshade,
  output logic [LIGHT_LEVEL_W-1:0] o_lightnum,
  output logic [LAMP_COUNT-1:0]    o_lightstate,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  light_ramp_state_t        r_state;
  light_ramp_state_t        w_state_nxt;
  logic [LIGHT_LEVEL_W-1:0] r_tgt_shade, w_tgt_shade_nxt;
  logic [LIGHT_LEVEL_W-1:0] r_tgt_lamps, w_tgt_lamps_nxt;
  logic [LIGHT_LEVEL_W-1:0] r_wshade, w_wshade_nxt;
  logic [LIGHT_LEVEL_W-1:0] r_lightnum, w_lightnum_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic                     w_upd_ready;
  logic                     w_xfer;
  logic                     w_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt_shade <= '0;
      r_tgt_lamps <= '0;
      r_wshade    <= '0;
      r_lightnum  <= '0;
      r_cnt       <= '0;
    end else begin
      r_tgt_shade <= w_tgt_shade_nxt;
      r_tgt_lamps <= w_tgt_lamps_nxt;
      r_wshade    <= w_wshade_nxt;
      r_lightnum  <= w_lightnum_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
`ifdef LIGHT_PREEMPT_EN
    w_upd_ready = (r_state != DONE);
`else
    w_upd_ready = (r_state == IDLE);
`endif
    w_xfer          = i_upd_valid && w_upd_ready;
    w_step          = (r_cnt == CNT_LAST);
    w_state_nxt     = r_state;
    w_tgt_shade_nxt = r_tgt_shade;
    w_tgt_lamps_nxt = r_tgt_lamps;
    w_wshade_nxt    = r_wshade;
    w_lightnum_nxt  = r_lightnum;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      IDLE: begin
        // Acceptance is handled by the transfer override below.
      end
      SHADE: begin
        if (r_wshade == r_tgt_shade) begin
          w_state_nxt = LAMPS;
          w_cnt_nxt   = '0;
        end else if (w_step) begin
          w_wshade_nxt = step_toward(r_wshade, r_tgt_shade);
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LAMPS: begin
        if (r_lightnum == r_tgt_lamps) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else if (w_step) begin
          w_lightnum_nxt = step_toward(r_lightnum, r_tgt_lamps);
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // An accepted target always restarts from SHADE. Mid-ramp (preempt build
    // only) the driven levels are held so the motor and lamps never jump, and
    // the superseded ramp never reaches DONE.
    if (w_xfer) begin
      w_tgt_shade_nxt = i_tgt_shade;
      w_tgt_lamps_nxt = i_tgt_lamps;
      w_wshade_nxt    = r_wshade;
      w_lightnum_nxt  = r_lightnum;
      w_cnt_nxt       = '0;
      w_state_nxt     = SHADE;
    end
  end

  lamp_thermo_decode u_thermo (
    .i_count (r_lightnum),
    .o_therm (o_lightstate)
  );

  assign o_upd_ready = w_upd_ready;
  assign o_wshade    = r_wshade;
  assign o_lightnum  = r_lightnum;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_lighting_ramp_controller.sv
module tb_lighting_ramp_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0, upd_valid1 = 1'b0;
  logic [3:0]  tgt_shade = '0, tgt_lamps = '0, tgt_shade1 = '0, tgt_lamps1 = '0;
  logic        upd_ready, upd_ready1, busy, busy1, done, done1;
  logic [3:0]  wshade, wshade1, lightnum, lightnum1;
  logic [15:0] lightstate, lightstate1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lighting_ramp_controller #(.STEP_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
    .i_tgt_shade(tgt_shade), .i_tgt_lamps(tgt_lamps), .o_wshade(wshade),
    .o_lightnum(lightnum), .o_lightstate(lightstate), .o_busy(busy), .o_done(done)
  );

  lighting_ramp_controller #(.STEP_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_upd_valid(upd_valid1), .o_upd_ready(upd_ready1),
    .i_tgt_shade(tgt_shade1), .i_tgt_lamps(tgt_lamps1), .o_wshade(wshade1),
    .o_lightnum(lightnum1), .o_lightstate(lightstate1), .o_busy(busy1), .o_done(done1)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a target for one edge (edge 0); returns in cycle 1.
  task automatic xfer(input logic [3:0] s, input logic [3:0] l);
    tgt_shade = s;
    tgt_lamps = l;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({wshade, lightnum, lightstate, busy, done} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ws=%0d ln=%0d ls=%h busy=%b done=%b want all 0",
               wshade, lightnum, lightstate, busy, done);
    end
    tick();
    n_checks++;
    if (upd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got rdy=%b busy=%b want 1/0", upd_ready, busy);
    end
  endtask

  task automatic test_ramp_up();
    logic [3:0] ews, eln;
    xfer(4'd3, 4'd5);
    for (int c = 1; c <= 36; c++) begin
      ews = (c >= 13) ? 4'd3 : 4'((c - 1) / 4);
      eln = (c < 14) ? 4'd0 : ((c >= 34) ? 4'd5 : 4'((c - 14) / 4));
      n_checks++;
      if (wshade !== ews || lightnum !== eln) begin
        n_fail++;
        $display("FAIL ramp_up_levels c=%0d got ws=%0d ln=%0d want ws=%0d ln=%0d",
                 c, wshade, lightnum, ews, eln);
      end
      n_checks++;
      if (done !== (c == 35) || busy !== (c <= 35) || upd_ready !== (c > 35)) begin
        n_fail++;
        $display("FAIL ramp_up_flags c=%0d got done=%b busy=%b rdy=%b want %b/%b/%b",
                 c, done, busy, upd_ready, (c == 35), (c <= 35), (c > 35));
      end
      if (c < 36) tick();
    end
    n_checks++;
    if (lightstate !== 16'h001F) begin
      n_fail++;
      $display("FAIL ramp_up_lightstate got %h want 001f", lightstate);
    end
  endtask

  task automatic test_ramp_down();
    logic [3:0] ews, eln;
    xfer(4'd0, 4'd2);
    for (int c = 1; c <= 28; c++) begin
      ews = (c >= 13) ? 4'd0 : 4'(3 - (c - 1) / 4);
      eln = (c < 14) ? 4'd5 : ((c >= 26) ? 4'd2 : 4'(5 - (c - 14) / 4));
      n_checks++;
      if (wshade !== ews || lightnum !== eln || done !== (c == 27)) begin
        n_fail++;
        $display("FAIL ramp_down c=%0d got ws=%0d ln=%0d done=%b want ws=%0d ln=%0d done=%b",
                 c, wshade, lightnum, done, ews, eln, (c == 27));
      end
      if (c < 28) tick();
    end
    n_checks++;
    if (lightstate !== 16'h0003 || upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_down_final got ls=%h rdy=%b want 0003/1", lightstate, upd_ready);
    end
  endtask

  task automatic test_zero_delta();
    xfer(4'd0, 4'd2);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (wshade !== 4'd0 || lightnum !== 4'd2 || busy !== (c <= 3) ||
          done !== (c == 3) || upd_ready !== (c == 4)) begin
        n_fail++;
        $display("FAIL zero_delta c=%0d got ws=%0d ln=%0d busy=%b done=%b rdy=%b want 0/2/%b/%b/%b",
                 c, wshade, lightnum, busy, done, upd_ready, (c <= 3), (c == 3), (c == 4));
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_reset_midramp();
    int ndone = 0;
    xfer(4'd7, 4'd9);
    for (int c = 1; c < 10; c++) tick();
    n_checks++;
    if (wshade !== 4'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midramp_pre c=10 got ws=%0d busy=%b want 2/1", wshade, busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({wshade, lightnum, lightstate, busy, done} !== 26'd0 || upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midramp_reset got ws=%0d ln=%0d ls=%h busy=%b done=%b rdy=%b want 0s rdy=1",
               wshade, lightnum, lightstate, busy, done, upd_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done === 1'b1 || busy !== 1'b0) ndone++;
    end
    n_checks++;
    if (ndone != 0 || wshade !== 4'd0) begin
      n_fail++;
      $display("FAIL midramp_after got activity=%0d ws=%0d want 0/0", ndone, wshade);
    end
  endtask

  task automatic test_update_in_lamps();
    int ndone = 0, done_at = -1;
`ifdef LIGHT_PREEMPT_EN
    logic       exp_rdy = 1'b1;
    int         exp_done_at = 14, drop_at = 8;
    logic [3:0] fin_ws = 4'd0, fin_ln = 4'd0;
`else
    logic       exp_rdy = 1'b0;
    int         exp_done_at = 15, drop_at = 10;
    logic [3:0] fin_ws = 4'd1, fin_ln = 4'd2;
`endif
    xfer(4'd1, 4'd2);
    for (int c = 1; c <= 20; c++) begin
      if (c == 7) begin
        tgt_shade = 4'd0;
        tgt_lamps = 4'd0;
        upd_valid = 1'b1;
        n_checks++;
        if (upd_ready !== exp_rdy || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL lamps_ready c=7 got rdy=%b busy=%b want %b/1", upd_ready, busy, exp_rdy);
        end
      end
      if (c == drop_at) upd_valid = 1'b0;
      if (c == 8) begin
        n_checks++;
        if (wshade !== 4'd1 || lightnum !== 4'd0) begin
          n_fail++;
          $display("FAIL lamps_hold c=8 got ws=%0d ln=%0d want 1/0", wshade, lightnum);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        done_at = c;
      end
      if (c < 20) tick();
    end
    n_checks++;
    if (ndone != 1 || done_at != exp_done_at) begin
      n_fail++;
      $display("FAIL lamps_done got count=%0d at=%0d want 1 at %0d", ndone, done_at, exp_done_at);
    end
    n_checks++;
    if (wshade !== fin_ws || lightnum !== fin_ln || upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lamps_final got ws=%0d ln=%0d rdy=%b want %0d/%0d/1",
               wshade, lightnum, upd_ready, fin_ws, fin_ln);
    end
  endtask

  task automatic test_step_one();
    logic [3:0] eln;
    n_checks++;
    if (upd_ready1 !== 1'b1 || lightnum1 !== 4'd0) begin
      n_fail++;
      $display("FAIL s1_start got rdy=%b ln=%0d want 1/0", upd_ready1, lightnum1);
    end
    tgt_shade1 = 4'd0;
    tgt_lamps1 = 4'd15;
    upd_valid1 = 1'b1;
    tick();
    upd_valid1 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      eln = (c < 2) ? 4'd0 : ((c >= 17) ? 4'd15 : 4'(c - 2));
      n_checks++;
      if (lightnum1 !== eln || wshade1 !== 4'd0 || done1 !== (c == 18)) begin
        n_fail++;
        $display("FAIL s1_ramp c=%0d got ln=%0d ws=%0d done=%b want ln=%0d ws=0 done=%b",
                 c, lightnum1, wshade1, done1, eln, (c == 18));
      end
      if (c < 19) tick();
    end
    n_checks++;
    if (lightstate1 !== 16'h7FFF || upd_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL s1_final got ls=%h rdy=%b want 7fff/1", lightstate1, upd_ready1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    tick();
    test_ramp_down();
    tick();
    test_zero_delta();
    tick();
    test_reset_midramp();
    test_update_in_lamps();
    tick();
    test_step_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
